ps2_line_debouncer: RTL and testbench
=====================================

// Module: ps2_line_debouncer
// PURPOSE
// - Two-channel synchronizer and debouncer for the PS/2 keyboard clock and data lines.
// - Sits between the raw FPGA pins and the PS/2 receiver's shift logic, which clocks on the falling edge of output O0.
// - Each channel passes a new level only after it has been stable for STABLE_CYCLES consecutive system clocks.
// - The two channels are identical and fully independent.
// PARAMETERS
// - STABLE_CYCLES  19    consecutive cycles a synchronized level must persist to be accepted; legal range >= 1
// - SYNC_STAGES    2     flip-flop synchronizer depth per channel; legal range >= 2
// - RESET_LEVEL    1'b1  reset value of the synchronizer flops and outputs (PS/2 lines idle high)
// PORTS
// - clk  in   1  system clock; all state updates on its rising edge
// - rst  in   1  synchronous, active-high reset
// - I0   in   1  raw channel 0 (PS/2 clock); asynchronous to clk
// - I1   in   1  raw channel 1 (PS/2 data); asynchronous to clk
// - O0   out  1  debounced channel 0; driven directly from a register
// - O1   out  1  debounced channel 1; driven directly from a register
// BEHAVIOUR
// - Per channel n, the state is:
//   - sync chain of SYNC_STAGES flops; s_n is the output of the last flop
//   - counter cnt_n, width $clog2(STABLE_CYCLES+1)
//   - output register O_n
// - Reset (rst=1 at a rising edge):
//   - sync flops = RESET_LEVEL; cnt_n = 0; O_n = RESET_LEVEL
//   - reset has priority over all other updates, including mid-count
// - Each rising edge with rst=0:
//   - the sync chain shifts in I_n
//   - if s_n == O_n: cnt_n <= 0 and O_n holds
//   - if s_n != O_n and cnt_n == STABLE_CYCLES-1: O_n <= s_n and cnt_n <= 0
//   - if s_n != O_n otherwise: cnt_n <= cnt_n + 1
// - Latency: after a clean input step that occurs before edge 1, O_n changes at edge SYNC_STAGES+STABLE_CYCLES, i.e. edge 21 with the defaults.
// - Glitch rejection:
//   - any excursion shorter than STABLE_CYCLES cycles (as seen at s_n) leaves O_n unchanged
//   - the first cycle back at O_n's level clears cnt_n, so no partial count survives a bounce
// - Boundaries:
//   - an excursion of exactly STABLE_CYCLES cycles is accepted
//   - cnt_n never exceeds STABLE_CYCLES-1 and never wraps
//   - with STABLE_CYCLES=1, O_n follows s_n one cycle later
// - O_n never toggles more than once per STABLE_CYCLES cycles.
// - No combinational path exists from I_n to O_n.
// - Channels share only clk and rst; simultaneous transitions on I0 and I1 are filtered independently with identical latency.
// - Elaboration fails (generate-time $error) if STABLE_CYCLES < 1 or SYNC_STAGES < 2.
// TESTING
// - Reset: hold rst for 3 cycles with I0=I1=0 -> O0=O1=1 during and immediately after reset; both fall at edge 21 after rst deasserts.
// - Clean step: I0 1->0 before edge 1, then held -> O0 stays 1 through edge 20 and is 0 from edge 21; O1 unaffected.
// - Glitch threshold: I1 low pulse of 18 cycles -> O1 stays 1; low pulse of 19 cycles -> O1 goes 0 for exactly 19 cycles, delayed 21 cycles.
// - Bounce train: I0 toggles every 5 cycles for 100 cycles, then settles low -> O0 stays 1 during bouncing and falls 21 cycles after the final edge.
// - Reset mid-count: I0 low for 10 cycles, then rst for 1 cycle while I0 stays low -> O0=1 after reset; O0 falls 21 cycles after rst deasserts.
// - Independence: I0 falls and I1 rises on the same cycle from O0=1/O1=0 -> both outputs change on the same edge, 21 cycles later.

Source files
------------

// File: rtl/ps2_line_debouncer.sv
// Two-channel synchronizer and debouncer for the PS/2 clock (channel 0) and data (channel 1) pins.
// A channel output follows its synchronized input only after that level has held for STABLE_CYCLES clocks.

module ps2_line_debouncer_ch #(
  parameter int   STABLE_CYCLES = 19,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q  <= '0;
      dout   <= RESET_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      // Any sample matching the current output discards a partial count.
      if (s == dout) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        dout  <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

module ps2_line_debouncer #(
  parameter int   STABLE_CYCLES = 19,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic I0,
  input  logic I1,
  output logic O0,
  output logic O1
);

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("ps2_line_debouncer: STABLE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ps2_line_debouncer: SYNC_STAGES must be >= 2");
  end

  // Channels share only clk and rst, so simultaneous edges see identical latency.
  ps2_line_debouncer_ch #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES),
    .RESET_LEVEL  (RESET_LEVEL)
  ) u_ch0 (
    .clk (clk),
    .rst (rst),
    .din (I0),
    .dout(O0)
  );

  ps2_line_debouncer_ch #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES),
    .RESET_LEVEL  (RESET_LEVEL)
  ) u_ch1 (
    .clk (clk),
    .rst (rst),
    .din (I1),
    .dout(O1)
  );

endmodule

// File: tb/tb_ps2_line_debouncer.sv
// Directed bench for ps2_line_debouncer: a window-based model checked every cycle,
// plus literal edge-count expectations for each scenario.

module tb_ps2_line_debouncer;

  localparam int   S    = 19;
  localparam int   SYNC = 2;
  localparam logic RL   = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic I0  = 1'b0;
  logic I1  = 1'b0;
  logic O0, O1;

  int checks = 0;
  int errors = 0;

  ps2_line_debouncer #(
    .STABLE_CYCLES(S),
    .SYNC_STAGES  (SYNC),
    .RESET_LEVEL  (RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .I0 (I0),
    .I1 (I1),
    .O0 (O0),
    .O1 (O1)
  );

  always #5 clk = ~clk;

  // Model: the output flips when the last S synchronized samples since reset all differ from it.
  bit   ipipe[2][$];
  bit   shist[2][$];
  logic m_o[2];
  bit   model_ok = 0;

  always @(posedge clk) begin
    bit raw[2];
    raw[0] = I0;
    raw[1] = I1;
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        ipipe[n].delete();
        for (int k = 0; k < SYNC; k++) ipipe[n].push_back(RL);
        shist[n].delete();
        m_o[n] = RL;
      end
      model_ok = 1;
    end else if (model_ok) begin
      for (int n = 0; n < 2; n++) begin
        bit s;
        bit all_diff;
        s = ipipe[n].pop_front();
        ipipe[n].push_back(raw[n]);
        shist[n].push_back(s);
        if (shist[n].size() > S) void'(shist[n].pop_front());
        all_diff = (shist[n].size() == S);
        foreach (shist[n][i]) if (shist[n][i] == m_o[n]) all_diff = 0;
        if (all_diff) m_o[n] = s;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if (O0 !== m_o[0] || O1 !== m_o[1]) begin
        errors++;
        $display("FAIL model t=%0t O0=%b O1=%b expected O0=%b O1=%b", $time, O0, O1, m_o[0], m_o[1]);
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Low pulse of len samples on I1 (starting before edge 1); reports low-output cycles and first low edge.
  task automatic pulse1(input int len, input int total, output int low_cnt, output int first_low);
    low_cnt   = 0;
    first_low = -1;
    @(negedge clk);
    I1 = 1'b0;
    for (int e = 1; e <= total; e++) begin
      if (e == len + 1) I1 = 1'b1;
      @(posedge clk);
      #1;
      if (O1 === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = e;
      end
    end
  endtask

  initial begin
    int lc, fl;

    // Reset with both lines low: outputs stay high, fall at edge 21 after release.
    edges(3);
    chk("reset_O0", O0, 1'b1);
    chk("reset_O1", O1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    edges(20);
    chk("post_reset_e20_O0", O0, 1'b1);
    chk("post_reset_e20_O1", O1, 1'b1);
    edges(1);
    chk("post_reset_e21_O0", O0, 1'b0);
    chk("post_reset_e21_O1", O1, 1'b0);

    // Clean step on I0.
    @(negedge clk);
    I0 = 1'b1;
    I1 = 1'b1;
    edges(25);
    chk("idle_O0", O0, 1'b1);
    chk("idle_O1", O1, 1'b1);
    @(negedge clk);
    I0 = 1'b0;
    edges(20);
    chk("step_e20_O0", O0, 1'b1);
    edges(1);
    chk("step_e21_O0", O0, 1'b0);
    chk("step_O1_unaffected", O1, 1'b1);
    @(negedge clk);
    I0 = 1'b1;
    edges(25);
    chk("step_restore_O0", O0, 1'b1);

    // Glitch threshold on I1.
    pulse1(18, 45, lc, fl);
    chk_int("glitch18_low_cycles", lc, 0);
    pulse1(19, 60, lc, fl);
    chk_int("pulse19_low_cycles", lc, 19);
    chk_int("pulse19_first_low_edge", fl, 21);
    edges(5);

    // Bounce train on I0, then settle low.
    for (int c = 0; c < 100; c++) begin
      I0 = ((c / 5) % 2 == 0) ? 1'b0 : 1'b1;
      edges(1);
      chk("bounce_O0_high", O0, 1'b1);
    end
    I0 = 1'b0;
    edges(20);
    chk("bounce_settle_e20_O0", O0, 1'b1);
    edges(1);
    chk("bounce_settle_e21_O0", O0, 1'b0);
    @(negedge clk);
    I0 = 1'b1;
    edges(25);
    chk("bounce_restore_O0", O0, 1'b1);

    // Reset in the middle of a count.
    @(negedge clk);
    I0 = 1'b0;
    edges(10);
    @(negedge clk);
    rst = 1'b1;
    edges(1);
    chk("midcount_reset_O0", O0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    edges(20);
    chk("midcount_e20_O0", O0, 1'b1);
    edges(1);
    chk("midcount_e21_O0", O0, 1'b0);

    // Independence: opposite simultaneous transitions.
    @(negedge clk);
    I0 = 1'b1;
    I1 = 1'b0;
    edges(30);
    chk("indep_pre_O0", O0, 1'b1);
    chk("indep_pre_O1", O1, 1'b0);
    @(negedge clk);
    I0 = 1'b0;
    I1 = 1'b1;
    edges(20);
    chk("indep_e20_O0", O0, 1'b1);
    chk("indep_e20_O1", O1, 1'b0);
    edges(1);
    chk("indep_e21_O0", O0, 1'b0);
    chk("indep_e21_O1", O1, 1'b1);

    edges(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
